// File: rtl/lpddr5_mem_subsys_pkg.sv
// Shared constants, DRAM command encoding and controller states for the
// single-channel LPDDR5 memory subsystem.
package lpddr5_params;

    localparam int ADDR_WIDTH     = 32;
    localparam int PRIORITY_WIDTH = 2;

    localparam int T_RCD = 4;
    localparam int T_CL  = 6;
    localparam int T_WR  = 4;
    localparam int T_RP  = 3;

    // Byte offset of the line index within an address (128-byte lines).
    localparam int LINE_SHIFT = 7;
    localparam int BUSY_W     = 4;

    typedef enum logic [2:0] {
        NOP,
        ACT,
        RD,
        WR,
        PRE
    } dram_cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_RCD,
        ST_WAIT_RW,
        ST_WAIT_RP
    } ctrl_state_t;

    function automatic logic [BUSY_W-1:0] cmd_busy_cycles(input dram_cmd_t cmd);
        logic [BUSY_W-1:0] cycles;
        case (cmd)
            ACT:     cycles = BUSY_W'(T_RCD);
            RD:      cycles = BUSY_W'(T_CL);
            WR:      cycles = BUSY_W'(T_WR);
            PRE:     cycles = BUSY_W'(T_RP);
            default: cycles = '0;
        endcase
        return cycles;
    endfunction

endpackage

// File: rtl/lpddr5_mem_subsys_dram_model.sv
// Behavioural LPDDR5 device: line array, per-command busy timer, open-row
// tracking and the read-data register returned when a read's latency expires.
module lpddr5_dram_model
    import lpddr5_params::*;
#(
    parameter int LW        = 1024,
    parameter int MEM_LINES = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  dram_cmd_t             dram_cmd,
    input  logic [ADDR_WIDTH-1:0] dram_addr,
    input  logic [LW-1:0]         dram_wdata,
    output logic                  dram_ready,
    output logic [LW-1:0]         dram_rdata
);

    localparam int IDX_W = $clog2(MEM_LINES);

    // NOTE: the array is deliberately never reset (a reset would fan out to
    // every bit); a 2-state type makes it start at zero instead.
    bit   [LW-1:0]     mem [MEM_LINES];

    logic [BUSY_W-1:0] busy_cnt;
    logic              busy;
    logic              row_open;
    logic              rd_pending;
    logic [IDX_W-1:0]  rd_idx;
    logic [IDX_W-1:0]  line_idx;
    logic              cmd_take;
    logic              do_write;
    logic              unused_addr_bits;

    assign line_idx   = dram_addr[LINE_SHIFT +: IDX_W];
    assign busy       = (busy_cnt != '0);
    assign dram_ready = !busy && (dram_cmd == NOP);
    assign cmd_take   = !busy && (dram_cmd != NOP);
    assign do_write   = cmd_take && (dram_cmd == WR) && row_open;

    // Address bits outside the line index alias or are ignored.
    assign unused_addr_bits = ^{dram_addr[ADDR_WIDTH-1:LINE_SHIFT+IDX_W],
                                dram_addr[LINE_SHIFT-1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_cnt   <= '0;
            row_open   <= 1'b0;
            rd_pending <= 1'b0;
            rd_idx     <= '0;
            dram_rdata <= '0;
        end else if (cmd_take) begin
            busy_cnt <= cmd_busy_cycles(dram_cmd);
            case (dram_cmd)
                ACT: row_open <= 1'b1;
                PRE: row_open <= 1'b0;
                RD: begin
                    // A read to a closed row still costs latency but returns nothing.
                    rd_pending <= row_open;
                    rd_idx     <= line_idx;
                end
                default: ;
            endcase
        end else if (busy) begin
            busy_cnt <= busy_cnt - 1'b1;
            if (busy_cnt == BUSY_W'(1) && rd_pending) begin
                dram_rdata <= mem[rd_idx];
                rd_pending <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[line_idx] <= dram_wdata;
        end
    end

endmodule

// File: rtl/lpddr5_mem_subsys.sv
// Single-channel LPDDR5 subsystem top: one-at-a-time valid/ready front end
// sequencing each request as closed-page ACT -> RD/WR -> PRE into the model.
module lpddr5_mem_subsys
    import lpddr5_params::*;
#(
    parameter int CHANNELS     = 2,
    parameter int DATA_BITS    = 32,
    parameter int BURST_LENGTH = 16,
    parameter int MEM_LINES    = 256,
    localparam int LW          = CHANNELS * DATA_BITS * BURST_LENGTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cmd_valid,
    input  logic                      cmd_rw,
    input  logic [PRIORITY_WIDTH-1:0] cmd_priority,
    input  logic [ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [LW-1:0]             cmd_wdata,
    output logic [LW-1:0]             cmd_rdata,
    output logic                      cmd_ready,
    output logic                      dram_ready
);

    ctrl_state_t               state_q;
    ctrl_state_t               state_d;
    dram_cmd_t                 dram_cmd;
    dram_cmd_t                 dram_cmd_d;
    logic                      cmd_ready_d;
    logic                      capture;
    logic                      rdata_load;

    logic                      req_rw;
    logic [PRIORITY_WIDTH-1:0] req_prio;
    logic [ADDR_WIDTH-1:0]     dram_addr;
    logic [LW-1:0]             dram_wdata;
    logic [LW-1:0]             dram_rdata;
    logic                      unused_req_prio;

    // Priority travels with the request but has no scheduling effect.
    assign unused_req_prio = ^req_prio;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // through the case can infer a latch.
        state_d     = state_q;
        dram_cmd_d  = NOP;
        cmd_ready_d = 1'b0;
        capture     = 1'b0;
        rdata_load  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    capture     = 1'b1;
                    cmd_ready_d = 1'b1;
                    dram_cmd_d  = ACT;
                    state_d     = ST_WAIT_RCD;
                end
            end
            ST_WAIT_RCD: begin
                if (dram_ready) begin
                    dram_cmd_d = req_rw ? WR : RD;
                    state_d    = ST_WAIT_RW;
                end
            end
            ST_WAIT_RW: begin
                if (dram_ready) begin
                    dram_cmd_d = PRE;
                    rdata_load = !req_rw;
                    state_d    = ST_WAIT_RP;
                end
            end
            ST_WAIT_RP: begin
                if (dram_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            dram_cmd   <= NOP;
            cmd_ready  <= 1'b0;
            cmd_rdata  <= '0;
            req_rw     <= 1'b0;
            req_prio   <= '0;
            dram_addr  <= '0;
            dram_wdata <= '0;
        end else begin
            state_q   <= state_d;
            dram_cmd  <= dram_cmd_d;
            cmd_ready <= cmd_ready_d;
            if (capture) begin
                req_rw     <= cmd_rw;
                req_prio   <= cmd_priority;
                dram_addr  <= cmd_addr;
                dram_wdata <= cmd_wdata;
            end
            if (rdata_load) begin
                cmd_rdata <= dram_rdata;
            end
        end
    end

    lpddr5_dram_model #(
        .LW        (LW),
        .MEM_LINES (MEM_LINES)
    ) u_dram (
        .clk        (clk),
        .rst        (rst),
        .dram_cmd   (dram_cmd),
        .dram_addr  (dram_addr),
        .dram_wdata (dram_wdata),
        .dram_ready (dram_ready),
        .dram_rdata (dram_rdata)
    );

endmodule

// File: tb/tb_lpddr5_mem_subsys.sv
// Self-checking bench for lpddr5_mem_subsys: scoreboarded reads against a
// line model, acceptance spacing, held-valid behaviour and mid-read reset.
module tb_lpddr5_mem_subsys;
    import lpddr5_params::*;

    localparam int LW        = 1024;
    localparam int READ_GAP  = 20;
    localparam int WRITE_GAP = 18;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      cmd_valid;
    logic                      cmd_rw;
    logic [PRIORITY_WIDTH-1:0] cmd_priority;
    logic [ADDR_WIDTH-1:0]     cmd_addr;
    logic [LW-1:0]             cmd_wdata;
    logic [LW-1:0]             cmd_rdata;
    logic                      cmd_ready;
    logic                      dram_ready;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [LW-1:0] mdl [int unsigned];
    logic [LW-1:0] exp_q [$];
    logic [LW-1:0] last_rdata = '0;

    int prev_acc   = 0;
    int prev_gap   = 0;
    bit prev_valid = 1'b0;

    lpddr5_mem_subsys dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_rw       (cmd_rw),
        .cmd_priority (cmd_priority),
        .cmd_addr     (cmd_addr),
        .cmd_wdata    (cmd_wdata),
        .cmd_rdata    (cmd_rdata),
        .cmd_ready    (cmd_ready),
        .dram_ready   (dram_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h (low 64 bits) at cycle %0d", tag, got[63:0], exp[63:0], cyc);
        end
    endtask

    function automatic int unsigned idx_of(input logic [ADDR_WIDTH-1:0] a);
        return int'(a[14:7]);
    endfunction

    function automatic logic [LW-1:0] mdl_get(input logic [ADDR_WIDTH-1:0] a);
        int unsigned i = idx_of(a);
        if (mdl.exists(i)) return mdl[i];
        return '0;
    endfunction

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    // Drive a request at the current negedge, wait (bounded) for the pulse.
    task automatic issue(input logic rw, input logic [PRIORITY_WIDTH-1:0] prio,
                         input logic [ADDR_WIDTH-1:0] addr, input logic [LW-1:0] wdata,
                         output int acc, output bit ok);
        cmd_rw       = rw;
        cmd_priority = prio;
        cmd_addr     = addr;
        cmd_wdata    = wdata;
        cmd_valid    = 1'b1;
        ok           = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                ok = 1'b1;
                break;
            end
        end
        acc       = cyc;
        cmd_valid = 1'b0;
        if (!ok) check("accept_timeout", 1'b0, 1'b1);
        else if (rw) mdl[idx_of(addr)] = wdata;
        else exp_q.push_back(mdl_get(addr));
    endtask

    task automatic finish_read(input int acc);
        logic [LW-1:0] exp;
        wait_cyc(acc + 13);
        check("rdata_hold", cmd_rdata, last_rdata);
        wait_cyc(acc + 14);
        exp = exp_q.pop_front();
        check("rdata", cmd_rdata, exp);
        last_rdata = exp;
    endtask

    task automatic xfer(input logic rw, input logic [PRIORITY_WIDTH-1:0] prio,
                        input logic [ADDR_WIDTH-1:0] addr, input logic [LW-1:0] wdata);
        int acc;
        bit ok;
        issue(rw, prio, addr, wdata, acc, ok);
        if (!ok) return;
        if (prev_valid) check("accept_gap", acc - prev_acc, prev_gap);
        check("dram_busy_after_act", dram_ready, 1'b0);
        @(negedge clk);
        check("ready_single_pulse", cmd_ready, 1'b0);
        if (!rw) finish_read(acc);
        prev_acc   = acc;
        prev_gap   = rw ? WRITE_GAP : READ_GAP;
        prev_valid = 1'b1;
        wait_cyc(acc + prev_gap - 1);
        check("dram_idle_before_next", dram_ready, 1'b1);
    endtask

    initial begin
        logic [LW-1:0] line;
        logic [LW-1:0] pat_a;
        logic [LW-1:0] pat_b;
        int            pulses [$];
        int            acc;
        bit            ok;

        rst          = 1'b1;
        cmd_valid    = 1'b0;
        cmd_rw       = 1'b0;
        cmd_priority = '0;
        cmd_addr     = '0;
        cmd_wdata    = '0;
        repeat (3) @(negedge clk);
        check("reset_cmd_ready", cmd_ready, 1'b0);
        check("reset_cmd_rdata", cmd_rdata, '0);
        check("reset_dram_ready", dram_ready, 1'b1);
        rst = 1'b0;
        @(negedge clk);

        line       = '0;
        line[31:0] = 32'hDEAD_BEEF;
        xfer(1'b1, 2'd0, 32'h0000_1000, line);
        xfer(1'b0, 2'd0, 32'h0000_1000, '0);

        xfer(1'b1, 2'd0, 32'h0000_1000, '1);
        xfer(1'b0, 2'd1, 32'h0000_1080, '0);
        xfer(1'b0, 2'd2, 32'h0000_1000, '0);
        xfer(1'b0, 2'd0, 32'h0001_107F, '0);

        // Same write traffic at priority 0 and 3: spacing checked by accept_gap.
        for (int i = 0; i < LW / 32; i++) begin
            pat_a[i*32 +: 32] = $urandom;
            pat_b[i*32 +: 32] = $urandom;
        end
        xfer(1'b1, 2'd0, 32'h0000_2000, pat_a);
        xfer(1'b1, 2'd3, 32'h0000_2000, pat_b);
        xfer(1'b0, 2'd3, 32'h0000_2000, '0);

        // Held valid across two reads: exactly two pulses, one full read apart.
        cmd_rw       = 1'b0;
        cmd_priority = 2'd0;
        cmd_addr     = 32'h0000_1000;
        cmd_valid    = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                pulses.push_back(cyc);
                if (pulses.size() == 2) cmd_valid = 1'b0;
            end
        end
        cmd_valid = 1'b0;
        check("hold_pulse_count", pulses.size(), 2);
        if (pulses.size() >= 1) check("hold_first_gap", pulses[0] - prev_acc, prev_gap);
        if (pulses.size() == 2) check("hold_pulse_gap", pulses[1] - pulses[0], READ_GAP);
        last_rdata = mdl_get(32'h0000_1000);
        check("hold_rdata", cmd_rdata, last_rdata);
        prev_valid = 1'b0;

        // Reset in WAIT_RW of a read drops it; a held request is taken right after.
        issue(1'b0, 2'd1, 32'h0000_2000, '0, acc, ok);
        if (ok) void'(exp_q.pop_back());
        wait_cyc(acc + 9);
        rst          = 1'b1;
        cmd_valid    = 1'b1;
        cmd_rw       = 1'b0;
        cmd_addr     = 32'h0000_1000;
        repeat (2) @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1'b0);
        check("rst_cmd_rdata", cmd_rdata, '0);
        check("rst_dram_ready", dram_ready, 1'b1);
        rst = 1'b0;
        @(negedge clk);
        check("rst_reaccept", cmd_ready, 1'b1);
        acc        = cyc;
        cmd_valid  = 1'b0;
        last_rdata = '0;
        exp_q.push_back(mdl_get(32'h0000_1000));
        @(negedge clk);
        check("rst_ready_single_pulse", cmd_ready, 1'b0);
        finish_read(acc);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
